// File: rtl/uart_tx_fifo_if.sv
// Byte-wide valid/ready write port into the UART transmit FIFO.
// The core side drives tx_data/tx_valid; the UART side returns tx_ready.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: 8N1 UART transmitter fed by a FIFO_DEPTH-entry byte FIFO, LSB first.
// Latency: push into an empty idle FIFO -> pop 1 clk later -> start bit 1 clk after pop.
// Backpressure: tx_ready drops while the FIFO is full or in reset; tx_valid then is ignored.
// Optional UART_TX_PARITY_EN: adds an even-parity bit between data bit 7 and stop.
module uart_tx_fifo #(
  parameter int CLKS_PER_TICK = 54,
  parameter int TICKS_PER_BIT = 16,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  uart_tx_fifo_if.slave                 tx,
  output logic                          data_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int TCW = $clog2(CLKS_PER_TICK);
  localparam int SCW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [7:0]     shift_q;
  logic [2:0]     bit_idx;
  logic [TCW-1:0] tick_cnt;
  logic [SCW-1:0] sub_cnt;
  logic           rst_done;
  logic           tick, bit_end, empty, push, load;
  logic           line_d, busy_d;
`ifdef UART_TX_PARITY_EN
  logic           parity_q;
`endif

  assign empty       = (fifo_count == '0);
  assign tx.tx_ready = rst_done && (fifo_count != DEPTH_C);
  assign push        = tx.tx_valid && tx.tx_ready;
  assign tick        = (tick_cnt == TCW'(CLKS_PER_TICK - 1));
  assign bit_end     = tick && (sub_cnt == SCW'(TICKS_PER_BIT - 1));

  // Marks the first clock after reset release so tx_ready stays low in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  // FIFO storage; contents need no reset because pointers/count gate reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx.tx_data;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Bit timing and shift register; every frame load restarts the bit clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      sub_cnt  <= '0;
      shift_q  <= '0;
      bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (load) begin
      tick_cnt <= '0;
      sub_cnt  <= '0;
      shift_q  <= mem[rd_ptr];
      bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= ^mem[rd_ptr];
`endif
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) sub_cnt <= bit_end ? '0 : sub_cnt + 1'b1;
      if (bit_end && state_q == DATA) begin
        shift_q <= {1'b0, shift_q[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; STOP chains straight into START when more bytes wait.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level and busy for the current state, registered below.
  always_comb begin
    line_d = 1'b1;
    busy_d = 1'b1;
    case (state_q)
      IDLE:   busy_d = 1'b0;
      START:  line_d = 1'b0;
      DATA:   line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: line_d = parity_q;
`endif
      STOP:   line_d = 1'b1;
      default: begin
        line_d = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  // Registered outputs keep the serial line glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= 1'b1;
      busy     <= 1'b0;
    end else begin
      data_out <= line_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with shortened bit timing (3 clk/tick, 4 ticks/bit).
// A receiver-style monitor decodes data_out and checks bytes against a queue
// that the stimulus fills; the stimulus also checks handshake and timing.
module tb_uart_tx_fifo;

  localparam int CPT = 3;
  localparam int TPB = 4;
  localparam int BIT = CPT * TPB;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * BIT;

  logic       clk;
  logic       reset;
  logic       data_out;
  logic       busy;
  logic [4:0] fifo_count;
  int         cyc;
  int         n_checks;
  int         n_pass;
  logic [7:0] sb [$];

  uart_tx_fifo_if tx_if ();

  uart_tx_fifo #(
    .CLKS_PER_TICK (CPT),
    .TICKS_PER_BIT (TPB),
    .FIFO_DEPTH    (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx         (tx_if.slave),
    .data_out   (data_out),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Waits for busy to rise then fall, then checks elapsed cycles since c0.
  task automatic wait_done(input string name, input int c0, input int exp_cyc);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    while (busy !== 1'b0 && n < 20 * FRAME) begin @(negedge clk); n++; end
    check(name, cyc - c0, exp_cyc);
  endtask

  // Counts idle-line violations over a window.
  task automatic idle_window(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (data_out !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0 || tx_if.tx_ready !== 1'b1)
        bad++;
    end
    check(name, bad, 0);
  endtask

  // Serial monitor: finds the start edge, samples each bit mid-period.
  initial begin : monitor
    logic       prev;
    logic       active;
    logic [7:0] sh;
    int         cnt;
    int         idx;
    prev   = 1'b1;
    active = 1'b0;
    sh     = '0;
    cnt    = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        active = 1'b0;
        prev   = 1'b1;
      end else if (!active) begin
        if (prev === 1'b1 && data_out === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
        end
        prev = data_out;
      end else begin
        cnt++;
        if (cnt % BIT == BIT / 2) begin
          idx = cnt / BIT;
          if (idx == 0) begin
            check("start_bit", data_out, 1'b0);
          end else if (idx <= 8) begin
            sh[idx-1] = data_out;
`ifdef UART_TX_PARITY_EN
          end else if (idx == 9) begin
            check("parity_bit", data_out, ^sh);
`endif
          end else begin
            check("stop_bit", data_out, 1'b1);
            if (sb.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_frame: got byte %0h, expected none", sh);
            end else begin
              check("frame_byte", sh, sb.pop_front());
            end
            active = 1'b0;
            prev   = 1'b1;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int c0;
    int n;
    int peak;
    int not_ready;
    n_checks        = 0;
    n_pass          = 0;
    reset           = 1'b0;
    tx_if.tx_valid  = 1'b0;
    tx_if.tx_data   = 8'h00;

    // Reset state, then idle after release.
    @(negedge clk);
    check("rst_data_out", data_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 5'd0);
    check("rst_ready", tx_if.tx_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    idle_window("idle_after_reset", 200);

    // Single byte 0x35: count 1 for a cycle, start bit 2 clk after push.
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h35;
    sb.push_back(8'h35);
    c0 = cyc;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    check("single_count1", fifo_count, 5'd1);
    check("single_pre_start", data_out, 1'b1);
    @(negedge clk);
    check("single_popped", fifo_count, 5'd0);
    check("single_not_started", data_out, 1'b1);
    @(negedge clk);
    check("single_start_edge", data_out, 1'b0);
    check("single_busy", busy, 1'b1);
    wait_done("single_frame_len", c0, 3 + FRAME);

    // Back-to-back burst 0x30..0x3F.
    peak      = 0;
    not_ready = 0;
    c0        = cyc;
    for (int i = 0; i < 16; i++) begin
      if (tx_if.tx_ready !== 1'b1) not_ready++;
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = 8'h30 + 8'(i);
      sb.push_back(8'h30 + 8'(i));
      @(negedge clk);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    tx_if.tx_valid = 1'b0;
    check("burst_ready", not_ready, 0);
    check("burst_peak", (peak == 15 || peak == 16), 1'b1);
    wait_done("burst_total_len", c0, 3 + 16 * FRAME);

    // Full FIFO: 0x40 in flight, 16 queued, 0xAA offered and dropped.
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h40;
    sb.push_back(8'h40);
    c0 = cyc;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 16; i++) begin
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = 8'h41 + 8'(i);
      sb.push_back(8'h41 + 8'(i));
      @(negedge clk);
    end
    tx_if.tx_data = 8'hAA;
    check("full_count", fifo_count, 5'd16);
    check("full_ready", tx_if.tx_ready, 1'b0);
    repeat (3) @(negedge clk);
    check("full_hold_count", fifo_count, 5'd16);
    tx_if.tx_valid = 1'b0;
    n = 0;
    while (fifo_count === 5'd16 && n < 2 * FRAME) begin @(negedge clk); n++; end
    check("after_pop_count", fifo_count, 5'd15);
    check("after_pop_ready", tx_if.tx_ready, 1'b1);
    wait_done("full_total_len", c0, 3 + 17 * FRAME);

    // Reset during data bit 3 of 0x55.
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h55;
    sb.push_back(8'h55);
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (4 * BIT + BIT / 2) @(negedge clk);
    check("pre_reset_bit3", data_out, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_data_out", data_out, 1'b1);
    check("async_busy", busy, 1'b0);
    check("async_count", fifo_count, 5'd0);
    check("async_ready", tx_if.tx_ready, 1'b0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_window("no_residual", 3 * FRAME);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h41;
    sb.push_back(8'h41);
    c0 = cyc;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    wait_done("post_reset_len", c0, 3 + FRAME);

`ifdef UART_TX_PARITY_EN
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h07;
    sb.push_back(8'h07);
    c0 = cyc;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    wait_done("parity07_len", c0, 3 + FRAME);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h03;
    sb.push_back(8'h03);
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    wait_done("parity03_len", c0, 3 + 2 * FRAME + 2);
`endif

    repeat (BIT) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter with a 16-entry byte FIFO.
- Serial output timing is derived from the same 16x-oversampling tick used by the UART receive path (54 clocks per tick at 100 MHz gives 115200 baud).
- Sits on the transmit side of the UART: the core writes bytes through a valid/ready handshake, and the block serialises them onto data_out, LSB first.
- Intended as the far-end source that drives a receiver's data_in, and as the TX half of the UART top.

Parameters:
- CLKS_PER_TICK, 54, clk cycles per 16x oversample tick; legal values are 2 or more.
- TICKS_PER_BIT, 16, oversample ticks per serial bit.
- FIFO_DEPTH, 16, byte entries; must be a power of two, 2 or more.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous reset, active-low; clears the block when 0.
- tx_data  input  8  byte to queue.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte this cycle.
- data_out  output  1  serial line; idles high.
- busy  output  1  a frame is being shifted out.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued (does not include the frame in flight).

Behaviour:
- Reset (reset=0, asynchronous) forces the following immediately, including mid-frame; no partial frame resumes after release:
  - data_out=1, busy=0, fifo_count=0, tx_ready=0.
  - FSM goes to IDLE; FIFO pointers and tick/bit counters clear.
- tx_ready is combinational: tx_ready = reset_released && (fifo_count != FIFO_DEPTH).
- Push happens on a clk edge where tx_valid && tx_ready.
  - tx_valid while full is ignored; the byte is dropped and the FIFO is unchanged.
- Pop occurs only when the FSM loads a frame.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- Tick generator:
  - Counter runs 0..CLKS_PER_TICK-1 and asserts tick for one cycle at terminal count.
  - Tick counter and sub-bit counter clear on every frame load, so every bit lasts exactly TICKS_PER_BIT*CLKS_PER_TICK clocks (864 with defaults).
- FSM states and transitions:
  - IDLE: data_out=1, busy=0. If FIFO is non-empty: pop into shift register, go to START. Pop-to-start-bit latency is 1 clk after the byte is present in the FIFO.
  - START: data_out=0 for one bit period, then go to DATA with bit index 0.
  - DATA: data_out=shift[0]; at the end of each bit period shift right and increment the index. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY: present only with the optional feature; see below.
  - STOP: data_out=1 for one bit period. At its last cycle:
    - If the FIFO is non-empty, pop and go directly to START, giving zero idle gap (frames back to back, 10 bit periods each).
    - Otherwise go to IDLE.
- busy is 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
- data_out is registered and glitch-free.
- A push arriving while the FIFO is empty and the FSM is IDLE gives:
  - fifo_count=1 for one cycle;
  - pop on the next edge;
  - start bit the edge after that.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is sent in a PARITY state between bit 7 and STOP.
  - Frame becomes 11 bit periods (9504 clocks with defaults).
- Undefined:
  - No PARITY state or logic is compiled.
  - Frame is 8N1, 10 bit periods (8640 clocks).

Test Plan:
- Reset then idle: hold reset=0 for 2 clk, release, run 2000 clk -> data_out=1, busy=0, fifo_count=0, tx_ready=1 throughout.
- Single byte: push 0x35 -> start bit edge 2 clk after push. Sample at mid-bit (432 + n*864 clk): 0,1,0,1,0,1,1,0,0,1. busy falls 8640 clk after the start edge.
- Back-to-back, loopback into UART RX: push 0x30..0x3F in 16 consecutive cycles.
  - fifo_count peaks at 15 or 16 and tx_ready stays 1.
  - 16 frames follow with no idle gap; total 138240 clk.
  - Receiver decodes '0'..'F' in order.
- Full/overflow: push 16 bytes while a frame is active, then push 0xAA with tx_valid=1.
  - tx_ready=0 and 0xAA is never transmitted.
  - After the next pop, tx_ready returns to 1 the same cycle fifo_count drops to 15.
- Reset mid-frame: push 0x55 and assert reset=0 during bit 3.
  - data_out goes to 1 asynchronously, busy=0, fifo_count=0.
  - After release, no residual bits appear; a new push of 0x41 transmits cleanly.
- Parity build (UART_TX_PARITY_EN): push 0x07 -> parity bit 1, then stop bit, frame 9504 clk. Push 0x03 -> parity bit 0.
